axis_pe_result_packer: RTL
==========================

Name: axis_pe_result_packer

Overview:
- Receive side of the PE stream path. Sits downstream of the PE stream wrapper, which emits one 8-bit result per 32-bit beat, zero-extended in tdata[7:0].
- Packs four consecutive results into one 32-bit word, little-endian by arrival, so the DMA write path carries 4x fewer beats.
- Honours tlast: partial words are flushed with tkeep. A bypass mode forwards beats unchanged.

Parameters:
- DATA_WIDTH, 32, stream word width on both ports.
- LANE_WIDTH, 8, width of one PE result lane taken from s_axis_tdata[LANE_WIDTH-1:0].
- LANES, DATA_WIDTH/LANE_WIDTH (4), derived; not to be overridden.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- en  in  1  1 = pack mode, 0 = bypass; sampled only at word boundary.
- s_axis_tready  out  1  slave ready.
- s_axis_tdata  in  DATA_WIDTH  PE result; only [LANE_WIDTH-1:0] used in pack mode.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tlast  in  1  end of packet.
- m_axis_tready  in  1  master ready.
- m_axis_tdata  out  DATA_WIDTH  packed word.
- m_axis_tvalid  out  1  master valid.
- m_axis_tlast  out  1  last word of packet.
- m_axis_tkeep  out  DATA_WIDTH/8  valid-byte mask.

Behaviour:
- Reset (async assert, sync-to-aclk deassert): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tkeep=0, lane count=0, assembly reg=0, mode=pack. Reset mid-word silently drops the partial word.
- Storage: assembly register (LANES-1 lanes), lane counter cnt (0..LANES-1), output register with its own valid.
- Beat accept: s_axis_tvalid && s_axis_tready.
- Completing beat: a beat with cnt==LANES-1, tlast=1, or mode=bypass.
- Non-completing beat: writes lane[cnt] and increments cnt. Its s_axis_tready is 1 unconditionally.
- Completing beat: s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - On accept, the output reg loads the assembly lanes 0..cnt-1 plus the current lane at cnt.
  - Unfilled lanes are zero.
  - tkeep = (1<<(cnt+1))-1, with 4'hF at a full word.
  - tlast = s_axis_tlast.
  - cnt and assembly are cleared on the same edge.
- Latency: m_axis_tvalid rises on the edge after the completing beat is accepted.
- Throughput: one beat per cycle sustained when m_axis_tready=1. Input throughput is then 4 beats per output word.
- Master handshake: output is held stable while m_axis_tvalid && !m_axis_tready.
  - The output reg clears valid on transfer, unless a completing beat is accepted on the same edge, in which case it reloads (back-to-back).
- Bypass (mode=0): every beat is completing. The output takes s_axis_tdata unmodified, tkeep=4'hF, tlast passthrough.
- Mode latch: en is latched into mode only when cnt==0. A toggle of en mid-word takes effect after the current word completes.
- tlast at cnt==0: one-lane word, tkeep=4'b0001.
- Upper bits of s_axis_tdata are ignored in pack mode.
- Simultaneous transfer-out and completing-in: the new word wins the output reg; no bubble.

Optional Feature:
- Macro: AXIS_PE_PACK_STATS_EN.
- Defined: adds outputs pkt_count[31:0] and word_count[31:0].
  - pkt_count increments on each master transfer with tlast=1.
  - word_count increments on every master transfer.
  - Both wrap 0xFFFFFFFF→0, reset to 0, and are cleared synchronously by input stats_clr (1 bit, priority over increment).
- Undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package axis_pe_pkg:
  - constants DATA_WIDTH, LANE_WIDTH, LANES, CNT_W=$clog2(LANES);
  - function keep_from_count(cnt) returning the tkeep mask.
- One sub-module, axis_pe_out_reg: single-entry output holding register with valid/ready, loading tdata/tlast/tkeep. Reused later by other stream blocks.

Test Plan:
- Pack, ready=1: beats 0x11,0x22,0x33,0x44 (tlast on 4th) -> one word 0x44332211, tkeep=F, tlast=1, one cycle after 4th accept.
- Partial flush: beats 0xAA,0xBB with tlast on 2nd -> word 0x0000BBAA, tkeep=3, tlast=1; next packet starts at lane 0.
- Backpressure: 8 beats 0x01..0x08, m_axis_tready low for 6 cycles after first word -> 0x04030201 held stable; s_axis_tready low only on 8th beat until drain; then 0x08070605.
- Bypass: en=0, beats 0xDEADBEEF, 0x12345678 (tlast) -> identical words, tkeep=F, tlast on 2nd; en toggled after beat 2 of a packed word takes effect only at next word.
- Reset mid-word: 2 beats accepted, aresetn pulsed low -> all outputs 0 immediately; next 4 beats produce a clean word with no stale lanes.
- Stats (macro defined): 3 packets of 5 beats -> word_count=6, pkt_count=3; stats_clr pulse -> both 0.

Source files
------------

// File: rtl/axis_pe_pkg.sv
// rtl/axis_pe_pkg.sv - shared constants and keep-mask helper for the PE result packer
package axis_pe_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LANE_WIDTH = 8;
    localparam int LANES      = DATA_WIDTH / LANE_WIDTH;
    localparam int CNT_W      = $clog2(LANES);
    localparam int KEEP_W     = DATA_WIDTH / 8;
    localparam int LANE_BYTES = LANE_WIDTH / 8;

    // Byte mask covering lanes 0..cnt; cnt == LANES-1 yields all ones.
    function automatic logic [KEEP_W-1:0] keep_from_count(input logic [CNT_W-1:0] cnt);
        logic [KEEP_W-1:0] keep;
        keep = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if ((i / LANE_BYTES) <= int'(cnt)) begin
                keep[i] = 1'b1;
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_pe_out_reg.sv
// rtl/axis_pe_out_reg.sv - single-entry stream holding register with valid/ready
module axis_pe_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] ld_tdata,
    input  logic                  ld_tlast,
    input  logic [KEEP_WIDTH-1:0] ld_tkeep,
    output logic                  in_ready,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep
);

    // A load on the same edge as a drain reloads without a bubble.
    assign in_ready = !m_axis_tvalid || m_axis_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ld_tdata;
            m_axis_tlast  <= ld_tlast;
            m_axis_tkeep  <= ld_tkeep;
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_pe_result_packer.sv
// rtl/axis_pe_result_packer.sv - packs four 8-bit PE results per word; AXIS_PE_PACK_STATS_EN adds counters
module axis_pe_result_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    en,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep
`ifdef AXIS_PE_PACK_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [31:0]             pkt_count,
    output logic [31:0]             word_count
`endif
);

    import axis_pe_pkg::*;

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    logic [CNT_W-1:0]                 cnt;
    logic [(LANES-1)*LANE_WIDTH-1:0]  asm_q;
    logic                             mode;
    logic                             cur_mode;
    logic                             completing;
    logic                             accept;
    logic                             load;
    logic                             out_ready;
    logic [LANE_WIDTH-1:0]            lane_in;
    logic [DATA_WIDTH-1:0]            pack_word;
    logic [DATA_WIDTH-1:0]            ld_tdata;
    logic [DATA_WIDTH/8-1:0]          ld_tkeep;

    always_comb begin
        // en only takes effect at a word boundary; mid-word the latched mode holds.
        cur_mode      = (cnt == '0) ? en : mode;
        completing    = (cnt == LAST_LANE) || s_axis_tlast || !cur_mode;
        s_axis_tready = completing ? out_ready : 1'b1;
        accept        = s_axis_tvalid && s_axis_tready;
        load          = accept && completing;
        lane_in       = s_axis_tdata[LANE_WIDTH-1:0];

        pack_word = '0;
        for (int i = 0; i < LANES - 1; i++) begin
            if (i < int'(cnt)) begin
                pack_word[i*LANE_WIDTH +: LANE_WIDTH] = asm_q[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (i == int'(cnt)) begin
                pack_word[i*LANE_WIDTH +: LANE_WIDTH] = lane_in;
            end
        end

        ld_tdata = cur_mode ? pack_word : s_axis_tdata;
        ld_tkeep = cur_mode ? keep_from_count(cnt) : '1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt   <= '0;
            asm_q <= '0;
            mode  <= 1'b1;
        end else begin
            mode <= cur_mode;
            if (accept) begin
                if (completing) begin
                    cnt   <= '0;
                    asm_q <= '0;
                end else begin
                    for (int i = 0; i < LANES - 1; i++) begin
                        if (i == int'(cnt)) begin
                            asm_q[i*LANE_WIDTH +: LANE_WIDTH] <= lane_in;
                        end
                    end
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    axis_pe_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (DATA_WIDTH / 8)
    ) u_out_reg (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .load          (load),
        .ld_tdata      (ld_tdata),
        .ld_tlast      (s_axis_tlast),
        .ld_tkeep      (ld_tkeep),
        .in_ready      (out_ready),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep)
    );

`ifdef AXIS_PE_PACK_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count  <= '0;
            word_count <= '0;
        end else if (stats_clr) begin
            pkt_count  <= '0;
            word_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            word_count <= word_count + 32'd1;
            if (m_axis_tlast) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end
`endif

endmodule
